// File: rtl/lsu_axi_master.sv
// MEM-stage load/store unit: turns one pipeline memory request into a single-beat
// AXI4-Lite read or write and stalls the pipeline while the transaction is in flight.
module lsu_axi_master #(
  parameter int unsigned ERR_STICKY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  mem_func3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        lsu_stall,
  output logic [31:0] DM_read_data,
  output logic [1:0]  Byte_Address,
  output logic        bus_err,
  output logic [31:0] ARADDR,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [31:0] AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR_AW,
    WR_B,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        aw_done;
  logic        w_done;
  logic        aw_fin;
  logic        w_fin;
  logic        err_q;
  logic        err_hold;
  logic [1:0]  byte_off;
  logic [3:0]  strb_fmt;
  logic [31:0] data_fmt;
  logic        accept;
  logic        unused_resp;

  // Only bit 1 of a response (SLVERR/DECERR) signals an error.
  assign unused_resp = ^{RRESP[0], BRESP[0]};

  assign accept    = (state == IDLE) && mem_req;
  assign lsu_stall = accept || ((state != IDLE) && (state != DONE));

  // Valids come from registered state only, never from the matching ready.
  assign ARVALID = (state == RD_A);
  assign RREADY  = (state == RD_D);
  assign AWVALID = (state == WR_AW) && !aw_done;
  assign WVALID  = (state == WR_AW) && !w_done;
  assign BREADY  = (state == WR_B);

  assign aw_fin = aw_done || (AWVALID && AWREADY);
  assign w_fin  = w_done  || (WVALID && WREADY);

  assign bus_err = ((state == DONE) && err_q) || ((ERR_STICKY != 0) && err_hold);

  always_comb begin
    strb_fmt = 4'b1111;
    data_fmt = mem_wdata;
    case (mem_func3)
      3'b000: begin
        strb_fmt = 4'b0001 << mem_addr[1:0];
        data_fmt = {4{mem_wdata[7:0]}};
      end
      3'b001: begin
        strb_fmt = 4'b0011 << {mem_addr[1], 1'b0};
        data_fmt = {2{mem_wdata[15:0]}};
      end
      default: begin
        strb_fmt = 4'b1111;
        data_fmt = mem_wdata;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_req) state_nxt = mem_we ? WR_AW : RD_A;
      RD_A:    if (ARREADY) state_nxt = RD_D;
      RD_D:    if (RVALID) state_nxt = DONE;
      WR_AW:   if (aw_fin && w_fin) state_nxt = WR_B;
      WR_B:    if (BVALID) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      err_q        <= 1'b0;
      err_hold     <= 1'b0;
      byte_off     <= '0;
      ARADDR       <= '0;
      AWADDR       <= '0;
      WDATA        <= '0;
      WSTRB        <= '0;
      DM_read_data <= '0;
      Byte_Address <= '0;
    end else begin
      if (accept) begin
        byte_off <= mem_addr[1:0];
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
        if (mem_we) begin
          AWADDR <= {mem_addr[31:2], 2'b00};
          WSTRB  <= strb_fmt;
          WDATA  <= data_fmt;
        end else begin
          ARADDR <= {mem_addr[31:2], 2'b00};
        end
      end
      if ((state == WR_AW) && AWVALID && AWREADY) aw_done <= 1'b1;
      if ((state == WR_AW) && WVALID && WREADY)   w_done  <= 1'b1;
      if ((state == RD_D) && RVALID) begin
        DM_read_data <= RDATA;
        Byte_Address <= byte_off;
        err_q        <= RRESP[1];
      end
      if ((state == WR_B) && BVALID) err_q <= BRESP[1];
      if ((state == DONE) && err_q) err_hold <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed self-checking bench for lsu_axi_master; the bus slave is driven by the tasks.
module tb_lsu_axi_master;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_func3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        lsu_stall;
  logic [31:0] DM_read_data;
  logic [1:0]  Byte_Address;
  logic        bus_err;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  int total;
  int bad;

  lsu_axi_master #(.ERR_STICKY(0)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
    .mem_func3(mem_func3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .lsu_stall(lsu_stall), .DM_read_data(DM_read_data), .Byte_Address(Byte_Address),
    .bus_err(bus_err), .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .WDATA(WDATA),
    .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY), .BRESP(BRESP),
    .BVALID(BVALID), .BREADY(BREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if ({ARVALID, RREADY, AWVALID, WVALID, BREADY, lsu_stall, bus_err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0000000",
               {ARVALID, RREADY, AWVALID, WVALID, BREADY, lsu_stall, bus_err});
    end
    total++;
    if ({DM_read_data, Byte_Address, ARADDR, AWADDR, WDATA, WSTRB} !== '0) begin
      bad++;
      $display("FAIL reset_data rd=%h ba=%b ar=%h aw=%h wd=%h ws=%b want all zero",
               DM_read_data, Byte_Address, ARADDR, AWADDR, WDATA, WSTRB);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_load_word();
    RDATA = 32'h8899_AABB;
    mem_req = 1'b1; mem_we = 1'b0; mem_func3 = 3'b010; mem_addr = 32'h0000_1006;
    #1;
    total++;
    if (lsu_stall !== 1'b1 || ARVALID !== 1'b0) begin
      bad++;
      $display("FAIL lw_accept stall=%b arvalid=%b want 1 0", lsu_stall, ARVALID);
    end
    step();
    total++;
    if (ARVALID !== 1'b1 || ARADDR !== 32'h0000_1004 || lsu_stall !== 1'b1) begin
      bad++;
      $display("FAIL lw_rd_a arvalid=%b araddr=%h stall=%b want 1 00001004 1",
               ARVALID, ARADDR, lsu_stall);
    end
    step();
    total++;
    if (RREADY !== 1'b1 || ARVALID !== 1'b0 || lsu_stall !== 1'b1) begin
      bad++;
      $display("FAIL lw_rd_d rready=%b arvalid=%b stall=%b want 1 0 1",
               RREADY, ARVALID, lsu_stall);
    end
    step();
    total++;
    if (lsu_stall !== 1'b0 || DM_read_data !== 32'h8899_AABB || Byte_Address !== 2'b10 ||
        bus_err !== 1'b0) begin
      bad++;
      $display("FAIL lw_done stall=%b data=%h ba=%b err=%b want 0 8899aabb 10 0",
               lsu_stall, DM_read_data, Byte_Address, bus_err);
    end
    mem_req = 1'b0;
    step();
    total++;
    if (lsu_stall !== 1'b0 || ARVALID !== 1'b0 || RREADY !== 1'b0) begin
      bad++;
      $display("FAIL lw_idle stall=%b arvalid=%b rready=%b want 0 0 0",
               lsu_stall, ARVALID, RREADY);
    end
  endtask

  task automatic test_store_lanes();
    logic [31:0] t_addr  [3];
    logic [31:0] t_wdata [3];
    logic [2:0]  t_f3    [3];
    logic [3:0]  e_strb  [3];
    logic [31:0] e_data  [3];
    logic [31:0] e_aw    [3];
    t_addr[0] = 32'h2003; t_wdata[0] = 32'h0000_00A5; t_f3[0] = 3'b000;
    e_strb[0] = 4'b1000;  e_data[0]  = 32'hA5A5_A5A5; e_aw[0] = 32'h2000;
    t_addr[1] = 32'h2002; t_wdata[1] = 32'h0000_1234; t_f3[1] = 3'b001;
    e_strb[1] = 4'b1100;  e_data[1]  = 32'h1234_1234; e_aw[1] = 32'h2000;
    t_addr[2] = 32'h3001; t_wdata[2] = 32'hDEAD_BEEF; t_f3[2] = 3'b010;
    e_strb[2] = 4'b1111;  e_data[2]  = 32'hDEAD_BEEF; e_aw[2] = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      mem_req = 1'b1; mem_we = 1'b1; mem_func3 = t_f3[i];
      mem_addr = t_addr[i]; mem_wdata = t_wdata[i];
      step();
      total++;
      if (AWVALID !== 1'b1 || WVALID !== 1'b1 || WSTRB !== e_strb[i] ||
          WDATA !== e_data[i] || AWADDR !== e_aw[i]) begin
        bad++;
        $display("FAIL store_lane%0d awv=%b wv=%b strb=%b data=%h aw=%h want 1 1 %b %h %h",
                 i, AWVALID, WVALID, WSTRB, WDATA, AWADDR, e_strb[i], e_data[i], e_aw[i]);
      end
      step();
      total++;
      if (BREADY !== 1'b1 || AWVALID !== 1'b0 || WVALID !== 1'b0) begin
        bad++;
        $display("FAIL store_wr_b%0d bready=%b awv=%b wv=%b want 1 0 0",
                 i, BREADY, AWVALID, WVALID);
      end
      step();
      total++;
      if (lsu_stall !== 1'b0 || BREADY !== 1'b0) begin
        bad++;
        $display("FAIL store_done%0d stall=%b bready=%b want 0 0", i, lsu_stall, BREADY);
      end
      mem_req = 1'b0;
      step();
    end
    total++;
    if (DM_read_data !== 32'h8899_AABB || Byte_Address !== 2'b10) begin
      bad++;
      $display("FAIL store_keeps_rd data=%h ba=%b want 8899aabb 10", DM_read_data, Byte_Address);
    end
  endtask

  task automatic test_aw_delay();
    logic exp_w;
    AWREADY = 1'b0;
    mem_req = 1'b1; mem_we = 1'b1; mem_func3 = 3'b010;
    mem_addr = 32'h4008; mem_wdata = 32'h1122_3344;
    step();
    for (int i = 0; i < 4; i++) begin
      exp_w = (i == 0);
      total++;
      if (AWVALID !== 1'b1 || AWADDR !== 32'h4008 || WVALID !== exp_w || BREADY !== 1'b0) begin
        bad++;
        $display("FAIL aw_delay c%0d awv=%b aw=%h wv=%b bready=%b want 1 00004008 %b 0",
                 i, AWVALID, AWADDR, WVALID, BREADY, exp_w);
      end
      if (i == 3) AWREADY = 1'b1;
      step();
    end
    total++;
    if (BREADY !== 1'b1 || AWVALID !== 1'b0 || WVALID !== 1'b0) begin
      bad++;
      $display("FAIL aw_delay_b bready=%b awv=%b wv=%b want 1 0 0", BREADY, AWVALID, WVALID);
    end
    step();
    total++;
    if (lsu_stall !== 1'b0) begin
      bad++;
      $display("FAIL aw_delay_done stall=%b want 0", lsu_stall);
    end
    mem_req = 1'b0;
    step();
  endtask

  task automatic test_read_error();
    RRESP = 2'b10; RDATA = 32'hCAFE_F00D;
    mem_req = 1'b1; mem_we = 1'b0; mem_func3 = 3'b100; mem_addr = 32'h5001;
    step();
    step();
    total++;
    if (bus_err !== 1'b0) begin
      bad++;
      $display("FAIL err_early bus_err=%b want 0", bus_err);
    end
    step();
    total++;
    if (bus_err !== 1'b1 || DM_read_data !== 32'hCAFE_F00D || Byte_Address !== 2'b01) begin
      bad++;
      $display("FAIL err_done err=%b data=%h ba=%b want 1 cafef00d 01",
               bus_err, DM_read_data, Byte_Address);
    end
    mem_req = 1'b0;
    RRESP = 2'b00;
    step();
    total++;
    if (bus_err !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse bus_err=%b want 0", bus_err);
    end
  endtask

  task automatic test_reset_mid();
    RVALID = 1'b0;
    mem_req = 1'b1; mem_we = 1'b0; mem_func3 = 3'b010; mem_addr = 32'h6000;
    step();
    step();
    step();
    total++;
    if (RREADY !== 1'b1 || lsu_stall !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_wait rready=%b stall=%b want 1 1", RREADY, lsu_stall);
    end
    rst = 1'b1;
    step();
    total++;
    if (ARVALID !== 1'b0 || RREADY !== 1'b0 || DM_read_data !== 32'h0 || lsu_stall !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid arv=%b rready=%b data=%h stall=%b want 0 0 00000000 1",
               ARVALID, RREADY, DM_read_data, lsu_stall);
    end
    mem_req = 1'b0;
    #1;
    total++;
    if (lsu_stall !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_noreq stall=%b want 0", lsu_stall);
    end
    rst = 1'b0;
    RVALID = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int  ar_cnt;
    int  aw_cnt;
    logic exp_stall;
    ar_cnt = 0;
    aw_cnt = 0;
    RDATA = 32'h0BAD_CAFE;
    mem_req = 1'b1; mem_we = 1'b0; mem_func3 = 3'b010;
    mem_addr = 32'h7000; mem_wdata = 32'h5566_7788;
    #1;
    for (int i = 0; i < 10; i++) begin
      exp_stall = (i <= 2) || (i >= 4 && i <= 6);
      total++;
      if (lsu_stall !== exp_stall) begin
        bad++;
        $display("FAIL b2b_stall c%0d got=%b want=%b", i, lsu_stall, exp_stall);
      end
      if (ARVALID && ARREADY) ar_cnt++;
      if (AWVALID && AWREADY) aw_cnt++;
      if (i == 3) begin
        mem_we = 1'b1;
        mem_addr = 32'h7004;
      end
      if (i == 7) mem_req = 1'b0;
      step();
    end
    total++;
    if (ar_cnt != 1 || aw_cnt != 1) begin
      bad++;
      $display("FAIL b2b_count ar=%0d aw=%0d want 1 1", ar_cnt, aw_cnt);
    end
    total++;
    if (DM_read_data !== 32'h0BAD_CAFE || Byte_Address !== 2'b00) begin
      bad++;
      $display("FAIL b2b_data data=%h ba=%b want 0badcafe 00", DM_read_data, Byte_Address);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    mem_req = 1'b0; mem_we = 1'b0; mem_func3 = 3'b000;
    mem_addr = '0; mem_wdata = '0;
    ARREADY = 1'b1; RDATA = '0; RRESP = 2'b00; RVALID = 1'b1;
    AWREADY = 1'b1; WREADY = 1'b1; BRESP = 2'b00; BVALID = 1'b1;
    test_reset();
    test_load_word();
    test_store_lanes();
    test_aw_delay();
    test_read_error();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
